payload_splitter: RTL and testbench

PAYLOAD_SPLITTER -- requirements
Module: payload_splitter

---
 rtl/payload_splitter.sv | 144 ++++++++++++++
 tb/tb_payload_splitter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/payload_splitter.sv
`default_nettype none
// ============================================================================
//  Module   : payload_splitter
//  Brief    : Splits each framed byte stream into a 24-bit start address and a
//             stream of pixel bytes. Optional per-frame pixel limit is enabled
//             by defining PAYLOAD_SPLITTER_LIMIT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module payload_splitter #(
   parameter int MAX_PIXELS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        axiiv,
   input  logic [7:0]  axiid,
   output logic        addr_axiov,
   output logic [23:0] addr_axiod,
   output logic        pixel_axiov,
   output logic [7:0]  pixel_axiod,
   output logic        frame_done,
   output logic        short_frame,
   output logic        overflow
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_PIXEL = 2'd2
   } state_t;

   localparam logic [16:0] c_pix_sat = 17'h1FFFF;

`ifdef PAYLOAD_SPLITTER_LIMIT_EN
   localparam logic [16:0] c_max_pix = 17'(MAX_PIXELS);
`endif

   state_t        state_q;
   logic          wait_q;
   logic [1:0]    byte_cnt_q;
   logic [15:0]   addr_hi_q;
   logic [16:0]   pix_cnt_q;
   logic [23:0]   addr_q;
   logic          addr_vld_q;
   logic [7:0]    pix_q;
   logic          pix_vld_q;
   logic          done_q;
   logic          short_q;
   logic          ovf_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         wait_q     <= 1'b1;
         byte_cnt_q <= 2'd0;
         addr_hi_q  <= 16'd0;
         pix_cnt_q  <= 17'd0;
         addr_q     <= 24'd0;
         addr_vld_q <= 1'b0;
         pix_q      <= 8'd0;
         pix_vld_q  <= 1'b0;
         done_q     <= 1'b0;
         short_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         addr_vld_q <= 1'b0;
         pix_vld_q  <= 1'b0;
         done_q     <= 1'b0;
         short_q    <= 1'b0;
         ovf_q      <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               // After reset, the tail of an aborted frame is ignored until axiiv drops.
               if (wait_q) begin
                  if (!axiiv) begin
                     wait_q <= 1'b0;
                  end
               end else if (axiiv) begin
                  addr_hi_q[15:8] <= axiid;
                  byte_cnt_q      <= 2'd1;
                  pix_cnt_q       <= 17'd0;
                  state_q         <= ST_ADDR;
               end
            end

            ST_ADDR: begin
               if (!axiiv) begin
                  short_q <= 1'b1;
                  state_q <= ST_IDLE;
               end else if (byte_cnt_q == 2'd1) begin
                  addr_hi_q[7:0] <= axiid;
                  byte_cnt_q     <= 2'd2;
               end else begin
                  addr_q     <= {addr_hi_q, axiid};
                  addr_vld_q <= 1'b1;
                  byte_cnt_q <= 2'd0;
                  state_q    <= ST_PIXEL;
               end
            end

            ST_PIXEL: begin
               if (axiiv) begin
                  if (pix_cnt_q != c_pix_sat) begin
                     pix_cnt_q <= pix_cnt_q + 17'd1;
                  end
`ifdef PAYLOAD_SPLITTER_LIMIT_EN
                  if (pix_cnt_q < c_max_pix) begin
                     pix_q     <= axiid;
                     pix_vld_q <= 1'b1;
                  end else if (pix_cnt_q == c_max_pix) begin
                     ovf_q <= 1'b1;
                  end
`else
                  pix_q     <= axiid;
                  pix_vld_q <= 1'b1;
`endif
               end else begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifndef PAYLOAD_SPLITTER_LIMIT_EN
   logic w_unused;
   assign w_unused = ^{pix_cnt_q, 17'(MAX_PIXELS)};
`endif

   assign addr_axiov  = addr_vld_q;
   assign addr_axiod  = addr_q;
   assign pixel_axiov = pix_vld_q;
   assign pixel_axiod = pix_q;
   assign frame_done  = done_q;
   assign short_frame = short_q;
   assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_payload_splitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_payload_splitter
//  Brief    : Directed plus random frames against a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_payload_splitter;

   localparam int TB_MAX = 4;

   typedef logic [7:0] byte_q_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        axiiv = 1'b0;
   logic [7:0]  axiid = 8'd0;
   logic        addr_axiov;
   logic [23:0] addr_axiod;
   logic        pixel_axiov;
   logic [7:0]  pixel_axiod;
   logic        frame_done;
   logic        short_frame;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   logic [23:0] exp_addr[$];
   logic [7:0]  exp_pix[$];
   int exp_done = 0, exp_short = 0, exp_ovf = 0;
   int obs_done = 0, obs_short = 0, obs_ovf = 0;

   logic last_v   = 1'b0;
   logic last_rst = 1'b0;

   payload_splitter #(.MAX_PIXELS(TB_MAX)) dut (
      .clk         (clk),
      .rst         (rst),
      .axiiv       (axiiv),
      .axiid       (axiid),
      .addr_axiov  (addr_axiov),
      .addr_axiod  (addr_axiod),
      .pixel_axiov (pixel_axiov),
      .pixel_axiod (pixel_axiod),
      .frame_done  (frame_done),
      .short_frame (short_frame),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Frame-level model: what a complete frame of these bytes should yield.
   task automatic model_frame(input byte_q_t f);
      int n;
      if (f.size() < 3) begin
         exp_short++;
         return;
      end
      exp_addr.push_back({f[0], f[1], f[2]});
      n = f.size() - 3;
      for (int i = 0; i < n; i++) begin
`ifdef PAYLOAD_SPLITTER_LIMIT_EN
         if (i < TB_MAX) exp_pix.push_back(f[3+i]);
`else
         exp_pix.push_back(f[3+i]);
`endif
      end
`ifdef PAYLOAD_SPLITTER_LIMIT_EN
      if (n > TB_MAX) exp_ovf++;
`endif
      exp_done++;
   endtask

   task automatic drive_byte(input logic [7:0] b);
      @(posedge clk); #1;
      axiiv = 1'b1;
      axiid = b;
   endtask

   task automatic drive_gap(input int gap);
      for (int i = 0; i < gap; i++) begin
         @(posedge clk); #1;
         axiiv = 1'b0;
         axiid = 8'($urandom);
      end
   endtask

   task automatic send_frame(input byte_q_t f, input int gap);
      model_frame(f);
      foreach (f[i]) drive_byte(f[i]);
      drive_gap(gap);
   endtask

   function automatic byte_q_t rand_frame(input int len);
      byte_q_t f;
      for (int i = 0; i < len; i++) f.push_back(8'($urandom));
      return f;
   endfunction

   always @(posedge clk) begin
      last_v   <= axiiv;
      last_rst <= rst;
   end

   always @(negedge clk) begin
      if (!last_rst) begin
         check("reset_outs", 64'({addr_axiov, pixel_axiov, frame_done, short_frame,
                                  overflow, addr_axiod, pixel_axiod}), 64'd0);
      end else begin
         if (addr_axiov) begin
            if (exp_addr.size() == 0) check("addr_extra", 64'd1, 64'd0);
            else check("addr", 64'(addr_axiod), 64'(exp_addr.pop_front()));
            check("addr_lat", 64'(last_v), 64'd1);
         end
         if (pixel_axiov) begin
            if (exp_pix.size() == 0) check("pix_extra", 64'd1, 64'd0);
            else check("pix", 64'(pixel_axiod), 64'(exp_pix.pop_front()));
            check("pix_lat", 64'(last_v), 64'd1);
            check("pix_with_addr", 64'(addr_axiov), 64'd0);
         end
         if (frame_done) begin
            obs_done++;
            check("done_lat", 64'(last_v), 64'd0);
         end
         if (short_frame) begin
            obs_short++;
            check("short_lat", 64'(last_v), 64'd0);
         end
         if (overflow) obs_ovf++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t f;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      drive_gap(2);

      send_frame('{8'h01, 8'h23, 8'h45, 8'hAA, 8'hBB}, 2);
      send_frame('{8'h10, 8'h20}, 2);
      send_frame('{8'hAB, 8'hCD, 8'hEF}, 2);
      send_frame('{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, 1);
      send_frame('{8'hFF, 8'hFF, 8'hFF, 8'h55}, 2);

      // Mid-frame reset after the 2nd pixel: only address and two pixels survive.
      f = rand_frame(13);
      exp_addr.push_back({f[0], f[1], f[2]});
      exp_pix.push_back(f[3]);
      exp_pix.push_back(f[4]);
      for (int i = 0; i < 5; i++) drive_byte(f[i]);
      @(posedge clk); #1;
      rst = 1'b0; axiiv = 1'b1; axiid = f[5];
      @(posedge clk); #1;
      rst = 1'b1; axiid = f[6];
      for (int i = 7; i < 13; i++) drive_byte(f[i]);
      drive_gap(1);
      send_frame('{8'h12, 8'h34, 8'h56, 8'h78}, 2);

      send_frame('{8'hC0, 8'hDE, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 2);

      for (int k = 0; k < 40; k++) begin
         send_frame(rand_frame(int'($urandom_range(1, 10))), int'($urandom_range(1, 3)));
      end

      repeat (5) @(posedge clk);
      check("frame_done_cnt", 64'(obs_done), 64'(exp_done));
      check("short_cnt", 64'(obs_short), 64'(exp_short));
      check("overflow_cnt", 64'(obs_ovf), 64'(exp_ovf));
      check("addr_missing", 64'(exp_addr.size()), 64'd0);
      check("pix_missing", 64'(exp_pix.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
